// File: rtl/m92_pkg.sv
// Shared types and constants for the M92 memory-path blocks.
// Contents:
//   rom_arb_state_t - ROM fetch arbiter FSM state (idle / waiting for ack)
//   ROM_ARB_CH0/1   - channel indices used by the arbiter and its chooser
//   sdr_addr_t      - SDRAM word address as produced by the address translator
package m92_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_WAIT} rom_arb_state_t;

    localparam logic ROM_ARB_CH0 = 1'b0;
    localparam logic ROM_ARB_CH1 = 1'b1;

    typedef logic [24:0] sdr_addr_t;

endpackage

// File: rtl/rom_fetch_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser.
// Ports:
//   eligible[1:0] in  per-channel request-eligible flags
//   last_grant    in  channel that won the previous grant
//   grant_valid   out at least one channel is eligible
//   grant_idx     out chosen channel (the one not granted last on a tie)
module rr_pick2
    import m92_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Choose a channel; on a tie the channel that did not win last time goes.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ROM_ARB_CH0;
        case (eligible)
            2'b00: begin
                grant_valid = 1'b0;
                grant_idx   = ROM_ARB_CH0;
            end
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = ROM_ARB_CH0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = ROM_ARB_CH1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last_grant;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = ROM_ARB_CH0;
            end
        endcase
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: shares the CPU-ROM SDRAM read channel between the V33
// main CPU fetch path (ch0) and the V35 sound CPU ROM fetch (ch1).
// Round-robin grant, one outstanding SDRAM read, one-cycle rdy pulse per
// returned word, and a wait watchdog that returns all-ones data and sets a
// sticky error if the SDRAM never acks.
//
// Optional build macro ROM_LINE_CACHE_EN: adds a one-entry line cache per
// channel (tag/data/valid, filled on every ack, cleared by flush). Without it
// flush is ignored.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   req0/addr0           ch0 request (level, held until rdy0) and address
//   rdy0/data0           ch0 data-valid pulse and read data
//   req1/addr1           ch1 request (level, held until rdy1) and address
//   rdy1/data1           ch1 data-valid pulse and read data
//   sdr_req/sdr_addr     SDRAM read request (level) and word address
//   sdr_ack/sdr_data     SDRAM one-cycle ack with same-cycle data
//   flush                invalidate cached lines
//   timeout_err          sticky watchdog timeout flag
module rom_fetch_arbiter
    import m92_pkg::*;
#(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 255
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              rdy0,
    output logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              rdy1,
    output logic [DATA_W-1:0] data1,
    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_addr,
    input  logic              sdr_ack,
    input  logic [DATA_W-1:0] sdr_data,
    input  logic              flush,
    output logic              timeout_err
);

    localparam int                CNT_W        = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT      = CNT_W'(MAX_WAIT);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = {DATA_W{1'b1}};

    rom_arb_state_t    state_r;
    logic              last_grant_r;
    logic              cur_ch_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    logic [1:0]        eligible_s;
    logic [1:0]        hit_s;
    logic              grant_valid_s;
    logic              grant_idx_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [DATA_W-1:0] ret_data_s;
    logic [DATA_W-1:0] hit_data0_s;
    logic [DATA_W-1:0] hit_data1_s;

    // A channel sitting in its own rdy cycle is masked so the dropped level
    // request of a finished fetch is not re-granted.
    assign eligible_s = {req1 & ~rdy1, req0 & ~rdy0};

    rr_pick2 u_pick (
        .eligible    (eligible_s),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Address of the channel about to be granted.
    always_comb begin
        grant_addr_s = addr0;
        if (grant_idx_s == ROM_ARB_CH1) begin
            grant_addr_s = addr1;
        end else begin
            grant_addr_s = addr0;
        end
    end

    // Return word: real SDRAM data on ack (ack beats a coincident timeout),
    // otherwise the all-ones timeout pattern.
    always_comb begin
        ret_data_s = TIMEOUT_DATA;
        if (sdr_ack) begin
            ret_data_s = sdr_data;
        end else begin
            ret_data_s = TIMEOUT_DATA;
        end
    end

`ifdef ROM_LINE_CACHE_EN
    logic [1:0]        valid_r;
    logic [ADDR_W-1:0] tag0_r;
    logic [ADDR_W-1:0] tag1_r;
    logic [DATA_W-1:0] line0_r;
    logic [DATA_W-1:0] line1_r;
    logic              fill_s;

    // Only a real ack fills an entry; timeout data never reaches the cache.
    assign fill_s = (state_r == ARB_WAIT) && sdr_ack;

    assign hit_s[0]    = eligible_s[0] & valid_r[0] & (addr0 == tag0_r);
    assign hit_s[1]    = eligible_s[1] & valid_r[1] & (addr1 == tag1_r);
    assign hit_data0_s = line0_r;
    assign hit_data1_s = line1_r;

    // Line entries: fill on ack; flush wins over a same-cycle fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 2'b00;
            tag0_r  <= {ADDR_W{1'b0}};
            tag1_r  <= {ADDR_W{1'b0}};
            line0_r <= {DATA_W{1'b0}};
            line1_r <= {DATA_W{1'b0}};
        end else begin
            if (fill_s) begin
                if (cur_ch_r == ROM_ARB_CH1) begin
                    tag1_r  <= sdr_addr;
                    line1_r <= sdr_data;
                end else begin
                    tag0_r  <= sdr_addr;
                    line0_r <= sdr_data;
                end
            end
            if (flush) begin
                valid_r <= 2'b00;
            end else if (fill_s) begin
                valid_r[cur_ch_r] <= 1'b1;
            end
        end
    end
`else
    logic unused_flush_s;

    assign unused_flush_s = flush;
    assign hit_s          = 2'b00;
    assign hit_data0_s    = {DATA_W{1'b0}};
    assign hit_data1_s    = {DATA_W{1'b0}};
`endif

    // Arbiter FSM: grant in IDLE, wait for ack or watchdog expiry in WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ARB_IDLE;
            last_grant_r <= ROM_ARB_CH1;
            cur_ch_r     <= ROM_ARB_CH0;
            wait_cnt_r   <= {CNT_W{1'b0}};
            rdy0         <= 1'b0;
            rdy1         <= 1'b0;
            data0        <= {DATA_W{1'b0}};
            data1        <= {DATA_W{1'b0}};
            sdr_req      <= 1'b0;
            sdr_addr     <= {ADDR_W{1'b0}};
            timeout_err  <= 1'b0;
        end else begin
            rdy0 <= 1'b0;
            rdy1 <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (|hit_s) begin
                        // Cache hits are served locally and pre-empt any miss.
                        if (hit_s[0]) begin
                            rdy0  <= 1'b1;
                            data0 <= hit_data0_s;
                        end
                        if (hit_s[1]) begin
                            rdy1  <= 1'b1;
                            data1 <= hit_data1_s;
                        end
                    end else if (grant_valid_s) begin
                        sdr_addr     <= grant_addr_s;
                        sdr_req      <= 1'b1;
                        last_grant_r <= grant_idx_s;
                        cur_ch_r     <= grant_idx_s;
                        wait_cnt_r   <= {CNT_W{1'b0}};
                        state_r      <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (sdr_ack || (wait_cnt_r == MAX_CNT)) begin
                        if (cur_ch_r == ROM_ARB_CH1) begin
                            rdy1  <= 1'b1;
                            data1 <= ret_data_s;
                        end else begin
                            rdy0  <= 1'b1;
                            data0 <= ret_data_s;
                        end
                        if (!sdr_ack) begin
                            timeout_err <= 1'b1;
                        end
                        sdr_req <= 1'b0;
                        state_r <= ARB_IDLE;
                    end else begin
                        // Saturates at MAX_CNT through the branch above.
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
                    end
                end
                default: begin
                    sdr_req <= 1'b0;
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
